matvec_engine: RTL and testbench

MATVEC_ENGINE -- requirements
Module: matvec_engine

---
 rtl/matvec_pkg.sv | 16 +
 rtl/matvec_engine_mac_lane.sv | 42 ++++
 rtl/matvec_engine.sv | 116 +++++++++++
 tb/tb_matvec_engine.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and default sizes for the matrix-vector engine.
package matvec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ROWS       = 8;
  localparam int DEF_COLS       = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_SIGNED     = 0;
  localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + $clog2(DEF_COLS);

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One multiply-accumulate lane: acc_q += ext(a) * ext(b) modulo 2^ACC_WIDTH.
module mac_lane
  import matvec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int SIGNED     = DEF_SIGNED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] prod;

  function automatic logic [ACC_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] x);
    logic [ACC_WIDTH-1:0] r;
    r = {ACC_WIDTH{(SIGNED != 0) && x[DATA_WIDTH-1]}};
    r[DATA_WIDTH-1:0] = x;
    return r;
  endfunction

  // Multiplying the extended operands at accumulator width gives the
  // two's-complement product already reduced modulo 2^ACC_WIDTH.
  assign prod = extend(a) * extend(b);

  // acc includes the current term so the caller can capture the final
  // total on the same edge that accumulates the last column.
  assign acc = acc_q + prod;

  always_ff @(posedge clk) begin
    if (!rst_n)   acc_q <= '0;
    else if (clr) acc_q <= '0;
    else if (en)  acc_q <= acc;
  end

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector multiply: ROWS parallel MAC lanes stepping over COLS columns.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(COLS),
  parameter int SIGNED     = DEF_SIGNED
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0]     a_matrix,
  input  logic [COLS*DATA_WIDTH-1:0]          b_vector,
  output logic                                busy,
  output logic                                done,
  output logic [ROWS*ACC_WIDTH-1:0]           c_vector,
  output logic [ACC_WIDTH+$clog2(ROWS)-1:0]   sum
);

  localparam int SUM_W = ACC_WIDTH + $clog2(ROWS);
  localparam int KW    = (COLS > 1) ? $clog2(COLS) : 1;

  state_t                          state;
  logic [KW-1:0]                   k;
  logic [ROWS*COLS*DATA_WIDTH-1:0] a_snap;
  logic [COLS*DATA_WIDTH-1:0]      b_snap;
  logic [ROWS*ACC_WIDTH-1:0]       lane_acc;
  logic [DATA_WIDTH-1:0]           b_cur;
  logic [SUM_W-1:0]                total;
  logic                            lane_en;
  logic                            lane_clr;

  function automatic logic [SUM_W-1:0] widen(input logic [ACC_WIDTH-1:0] x);
    logic [SUM_W-1:0] r;
    r = {SUM_W{(SIGNED != 0) && x[ACC_WIDTH-1]}};
    r[ACC_WIDTH-1:0] = x;
    return r;
  endfunction

  // Abort clears the lanes; so does accepting a new start.
  assign lane_en  = (state == RUN) && !abort;
  assign lane_clr = abort || ((state == IDLE) && start);
  assign b_cur    = b_snap[int'(k)*DATA_WIDTH +: DATA_WIDTH];

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SIGNED     (SIGNED)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (lane_en),
      .clr   (lane_clr),
      .a     (a_snap[(r*COLS + int'(k))*DATA_WIDTH +: DATA_WIDTH]),
      .b     (b_cur),
      .acc   (lane_acc[r*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  always_comb begin
    total = '0;
    for (int r = 0; r < ROWS; r++)
      total = total + widen(lane_acc[r*ACC_WIDTH +: ACC_WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      a_snap   <= '0;
      b_snap   <= '0;
      c_vector <= '0;
      sum      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            a_snap <= a_matrix;
            b_snap <= b_vector;
            k      <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            k     <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (k == KW'(COLS - 1)) begin
            k        <= '0;
            c_vector <= lane_acc;
            sum      <= total;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Bench for matvec_engine: default unsigned, signed and a 4x3 instance.
module tb_matvec_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rst2_n;
  logic         start0, abort0, start1, abort1, start2, abort2;
  logic [511:0] a0, a1;
  logic [63:0]  b0, b1;
  logic [95:0]  a2;
  logic [23:0]  b2;
  logic         busy0, done0, busy1, done1, busy2, done2;
  logic [151:0] c0, c1;
  logic [21:0]  s0, s1;
  logic [71:0]  c2;
  logic [19:0]  s2;

  int vectors = 0;
  int errors  = 0;

  int          ma[8][8];
  int          mb[8];
  logic [63:0] exp_c[8];
  logic [63:0] exp_sum;
  logic [511:0] tmpa;
  logic [63:0]  tmpb;

  matvec_engine u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .a_matrix(a0), .b_vector(b0), .busy(busy0), .done(done0),
    .c_vector(c0), .sum(s0)
  );

  matvec_engine #(.SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a_matrix(a1), .b_vector(b1), .busy(busy1), .done(done1),
    .c_vector(c1), .sum(s1)
  );

  matvec_engine #(.ROWS(4), .COLS(3)) u2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .abort(abort2),
    .a_matrix(a2), .b_vector(b2), .busy(busy2), .done(done2),
    .c_vector(c2), .sum(s2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain dot products, wrapped to the accumulator and sum widths.
  task automatic model(input int rows, input int cols, input int aw, input int sw, input bit sgn);
    longint tot, acc, v;
    tot = 0;
    for (int r = 0; r < 8; r++) exp_c[r] = '0;
    for (int r = 0; r < rows; r++) begin
      acc = 0;
      for (int c = 0; c < cols; c++) acc += longint'(ma[r][c]) * longint'(mb[c]);
      exp_c[r] = 64'(acc) & ((64'd1 << aw) - 64'd1);
      v = longint'(exp_c[r]);
      if (sgn && exp_c[r][aw-1]) v = v - (longint'(1) << aw);
      tot += v;
    end
    exp_sum = 64'(tot) & ((64'd1 << sw) - 64'd1);
  endtask

  task automatic fill_random(input bit sgn);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ma[r][c] = sgn ? int'($urandom_range(255, 0)) - 128 : int'($urandom_range(255, 0));
    for (int c = 0; c < 8; c++)
      mb[c] = sgn ? int'($urandom_range(255, 0)) - 128 : int'($urandom_range(255, 0));
  endtask

  function automatic logic [511:0] pack_a(input int rows, input int cols);
    logic [511:0] v;
    v = '0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) v[(r*cols+c)*8 +: 8] = ma[r][c][7:0];
    return v;
  endfunction

  function automatic logic [63:0] pack_b(input int cols);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < cols; c++) v[c*8 +: 8] = mb[c][7:0];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    fill_random(0);
    a0 = pack_a(8, 8); b0 = pack_b(8); a1 = a0; b1 = b0;
    start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    tick(); tick();
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_ctrl0 busy=%b done=%b want 0 0", busy0, done0); end
    vectors++; if (c0 !== '0 || s0 !== '0) begin errors++; $display("FAIL reset_data0 c=%h sum=%h want 0", c0, s0); end
    vectors++; if (busy1 !== 1'b0 || c1 !== '0 || s1 !== '0) begin errors++; $display("FAIL reset_u1 busy=%b c=%h sum=%h want 0", busy1, c1, s1); end
    vectors++; if (busy2 !== 1'b0 || c2 !== '0 || s2 !== '0) begin errors++; $display("FAIL reset_u2 busy=%b c=%h sum=%h want 0", busy2, c2, s2); end
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    int n;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ma[r][c] = r + c;
    for (int c = 0; c < 8; c++) mb[c] = 1;
    a0 = pack_a(8, 8); b0 = pack_b(8);
    start0 = 1'b1; tick(); start0 = 1'b0;
    vectors++; if (busy0 !== 1'b1) begin errors++; $display("FAIL ramp_busy got %b want 1", busy0); end
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++; if (n != 8) begin errors++; $display("FAIL ramp_latency got %0d want 8", n); end
    for (int r = 0; r < 8; r++) begin
      vectors++;
      if (c0[r*19 +: 19] !== 19'(8*r + 28)) begin errors++; $display("FAIL ramp_c[%0d] got %0d want %0d", r, c0[r*19 +: 19], 8*r + 28); end
    end
    vectors++; if (s0 !== 22'd448) begin errors++; $display("FAIL ramp_sum got %0d want 448", s0); end
    tick();
    vectors++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL ramp_pulse done=%b busy=%b want 0 0", done0, busy0); end
  endtask

  task automatic test_signed_extreme();
    int n;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ma[r][c] = -128;
    for (int c = 0; c < 8; c++) mb[c] = -128;
    a1 = pack_a(8, 8); b1 = pack_b(8);
    start1 = 1'b1; tick(); start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++; if (n != 8) begin errors++; $display("FAIL signed_latency got %0d want 8", n); end
    for (int r = 0; r < 8; r++) begin
      vectors++;
      if (c1[r*19 +: 19] !== 19'd131072) begin errors++; $display("FAIL signed_c[%0d] got %0d want 131072", r, c1[r*19 +: 19]); end
    end
    vectors++; if (s1 !== 22'd1048576) begin errors++; $display("FAIL signed_sum got %0d want 1048576", s1); end
    tick();
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      fill_random(0); model(8, 8, 19, 22, 0);
      a0 = pack_a(8, 8); b0 = pack_b(8);
      start0 = 1'b1; tick(); start0 = 1'b0;
      n = 0;
      while (done0 !== 1'b1 && n < 40) begin tick(); n++; end
      for (int r = 0; r < 8; r++) begin
        vectors++;
        if (c0[r*19 +: 19] !== exp_c[r][18:0]) begin errors++; $display("FAIL rand_u_c[%0d] got %0d want %0d", r, c0[r*19 +: 19], exp_c[r][18:0]); end
      end
      vectors++; if (s0 !== exp_sum[21:0]) begin errors++; $display("FAIL rand_u_sum got %0d want %0d", s0, exp_sum[21:0]); end
      tick();
      fill_random(1); model(8, 8, 19, 22, 1);
      a1 = pack_a(8, 8); b1 = pack_b(8);
      start1 = 1'b1; tick(); start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 40) begin tick(); n++; end
      for (int r = 0; r < 8; r++) begin
        vectors++;
        if (c1[r*19 +: 19] !== exp_c[r][18:0]) begin errors++; $display("FAIL rand_s_c[%0d] got %h want %h", r, c1[r*19 +: 19], exp_c[r][18:0]); end
      end
      vectors++; if (s1 !== exp_sum[21:0]) begin errors++; $display("FAIL rand_s_sum got %h want %h", s1, exp_sum[21:0]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int first, second, pulses;
    logic [151:0] r1, r2, ev;
    fill_random(0); model(8, 8, 19, 22, 0);
    a0 = pack_a(8, 8); b0 = pack_b(8);
    ev = '0;
    for (int r = 0; r < 8; r++) ev[r*19 +: 19] = exp_c[r][18:0];
    first = -1; second = -1; pulses = 0; r1 = '0; r2 = '0;
    start0 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done0 === 1'b1) begin
        pulses++;
        if (pulses == 1) begin first = i; r1 = c0; end
        else if (pulses == 2) begin second = i; r2 = c0; end
      end
    end
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (done0 === 1'b1) pulses++; end
    vectors++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    vectors++; if (second - first - 1 != 9) begin errors++; $display("FAIL b2b_gap got %0d want 9", second - first - 1); end
    vectors++; if (r1 !== ev) begin errors++; $display("FAIL b2b_first got %h want %h", r1, ev); end
    vectors++; if (r2 !== r1) begin errors++; $display("FAIL b2b_same got %h want %h", r2, r1); end
  endtask

  task automatic test_operand_change();
    int n;
    bit held;
    logic [151:0] prev;
    logic [21:0]  prev_s;
    prev = c0; prev_s = s0;
    fill_random(0); model(8, 8, 19, 22, 0);
    a0 = pack_a(8, 8); b0 = pack_b(8);
    start0 = 1'b1; tick(); start0 = 1'b0;
    a0 = '0; b0 = '0;
    n = 0; held = 1'b1;
    while (done0 !== 1'b1 && n < 40) begin
      if (c0 !== prev || s0 !== prev_s) held = 1'b0;
      tick(); n++;
    end
    vectors++; if (!held) begin errors++; $display("FAIL hold_during_run got changed want held"); end
    vectors++; if (n != 8) begin errors++; $display("FAIL opchg_latency got %0d want 8", n); end
    for (int r = 0; r < 8; r++) begin
      vectors++;
      if (c0[r*19 +: 19] !== exp_c[r][18:0]) begin errors++; $display("FAIL opchg_c[%0d] got %0d want %0d", r, c0[r*19 +: 19], exp_c[r][18:0]); end
    end
    vectors++; if (s0 !== exp_sum[21:0]) begin errors++; $display("FAIL opchg_sum got %0d want %0d", s0, exp_sum[21:0]); end
    tick();
  endtask

  task automatic test_abort();
    int n, seen;
    logic [151:0] prev;
    logic [21:0]  prev_s;
    prev = c0; prev_s = s0;
    fill_random(0); model(8, 8, 19, 22, 0);
    a0 = pack_a(8, 8); b0 = pack_b(8);
    start0 = 1'b1; tick(); start0 = 1'b0;
    tick(); tick(); tick();
    abort0 = 1'b1; tick(); abort0 = 1'b0;
    vectors++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL abort_state busy=%b done=%b want 0 0", busy0, done0); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done0 === 1'b1) seen++; end
    vectors++; if (seen != 0) begin errors++; $display("FAIL abort_nodone got %0d pulses want 0", seen); end
    vectors++; if (c0 !== prev || s0 !== prev_s) begin errors++; $display("FAIL abort_keep got %h/%h want %h/%h", c0, s0, prev, prev_s); end
    start0 = 1'b1; abort0 = 1'b1; tick(); start0 = 1'b0; abort0 = 1'b0;
    vectors++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_wins busy got %b want 0", busy0); end
    start0 = 1'b1; tick(); start0 = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++; if (n != 8) begin errors++; $display("FAIL abort_rerun_latency got %0d want 8", n); end
    for (int r = 0; r < 8; r++) begin
      vectors++;
      if (c0[r*19 +: 19] !== exp_c[r][18:0]) begin errors++; $display("FAIL abort_rerun_c[%0d] got %0d want %0d", r, c0[r*19 +: 19], exp_c[r][18:0]); end
    end
    tick();
  endtask

  task automatic test_small_reset();
    int n, seen;
    fill_random(0); model(4, 3, 18, 20, 0);
    tmpa = pack_a(4, 3); tmpb = pack_b(3); a2 = tmpa[95:0]; b2 = tmpb[23:0];
    start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++; if (n != 3) begin errors++; $display("FAIL small_latency got %0d want 3", n); end
    vectors++; if (s2 !== exp_sum[19:0]) begin errors++; $display("FAIL small_sum got %0d want %0d", s2, exp_sum[19:0]); end
    tick();
    fill_random(0); model(4, 3, 18, 20, 0);
    tmpa = pack_a(4, 3); tmpb = pack_b(3); a2 = tmpa[95:0]; b2 = tmpb[23:0];
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick();
    rst2_n = 1'b0; tick(); rst2_n = 1'b1;
    vectors++; if (busy2 !== 1'b0 || done2 !== 1'b0 || c2 !== '0 || s2 !== '0) begin errors++; $display("FAIL small_midreset busy=%b done=%b c=%h sum=%h want all 0", busy2, done2, c2, s2); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done2 === 1'b1) seen++; end
    vectors++; if (seen != 0) begin errors++; $display("FAIL small_nodone got %0d pulses want 0", seen); end
    start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++; if (n != 3) begin errors++; $display("FAIL small_fresh_latency got %0d want 3", n); end
    for (int r = 0; r < 4; r++) begin
      vectors++;
      if (c2[r*18 +: 18] !== exp_c[r][17:0]) begin errors++; $display("FAIL small_c[%0d] got %0d want %0d", r, c2[r*18 +: 18], exp_c[r][17:0]); end
    end
    vectors++; if (s2 !== exp_sum[19:0]) begin errors++; $display("FAIL small_fresh_sum got %0d want %0d", s2, exp_sum[19:0]); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    abort0 = 1'b0; abort1 = 1'b0; abort2 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    test_reset();
    test_ramp();
    test_signed_extreme();
    test_random();
    test_back_to_back();
    test_operand_change();
    test_abort();
    test_small_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
